// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU word/opcode and the requester vector used by the
// shared-ALU arbiter.
package cpu_types_pkg;

  parameter int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } aluop_t;

  // Number of execute-stage requesters sharing the ALU.
  parameter int ALU_NREQ = 2;
  typedef logic [ALU_NREQ-1:0] alureq_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter for the shared ALU. Round-robin by default; with
// ALU_ARB_FIXED_PRIO_EN defined requester 0 always wins contention and no
// fairness state is kept.
module rr_arbiter2
  import cpu_types_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic    CLK,
  input  logic    RST,
  input  alureq_t req_valid,
  input  logic    slot_free,
  output logic    grant_id,
  output logic    grant_valid
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 1 only wins when requester 0 is idle.
  always_comb begin
    grant_id    = 1'b0;
    grant_valid = 1'b0;
    if (req_valid[0]) begin
      grant_id = 1'b0;
    end else begin
      grant_id = 1'b1;
    end
    if (slot_free && (req_valid != 2'b00)) begin
      grant_valid = 1'b1;
    end else begin
      grant_valid = 1'b0;
    end
  end

`else

  logic last_grant_q;
  logic last_grant_d;

  // Fairness pointer moves only when a grant is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      last_grant_d = grant_id;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Fairness pointer register; reset so RESET_PRIO wins the first contention.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= ~RESET_PRIO;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Round-robin select: a lone requester wins, contention goes to the
  // requester that was not granted last.
  always_comb begin
    grant_id    = 1'b0;
    grant_valid = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
    if (slot_free && (req_valid != 2'b00)) begin
      grant_valid = 1'b1;
    end else begin
      grant_valid = 1'b0;
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two execute-stage requesters.
// Arbitrates with rr_arbiter2, drives the ALU from the granted requester and
// captures the ALU result into a one-entry registered output slot tagged with
// the issuing requester. Optional build macro: ALU_ARB_FIXED_PRIO_EN selects
// fixed priority (requester 0 first) instead of round-robin.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  alureq_t                req_valid,
  output alureq_t                req_ready,
  input  aluop_t  [ALU_NREQ-1:0] req_aluop,
  input  word_t   [ALU_NREQ-1:0] req_porta,
  input  word_t   [ALU_NREQ-1:0] req_portb,
  output alureq_t                resp_valid,
  input  alureq_t                resp_ready,
  output word_t                  resp_portout,
  output logic                   resp_negative,
  output logic                   resp_overflow,
  output logic                   resp_zero,
  output aluop_t                 alu_aluop,
  output word_t                  alu_porta,
  output word_t                  alu_portb,
  input  word_t                  alu_portout,
  input  logic                   alu_negative,
  input  logic                   alu_overflow,
  input  logic                   alu_zero
);

  logic  out_valid_q, out_valid_d;
  logic  out_id_q,    out_id_d;
  word_t result_q,    result_d;
  logic  neg_q,       neg_d;
  logic  ovf_q,       ovf_d;
  logic  zero_q,      zero_d;

  logic  slot_free_s;
  logic  grant_id_s;
  logic  grant_valid_s;

  // The slot can take a new result when empty or being consumed by its owner
  // this cycle; nothing is accepted while reset is asserted.
  assign slot_free_s = ~RST & (~out_valid_q | resp_ready[out_id_q]);

  rr_arbiter2 #(
    .RESET_PRIO (RESET_PRIO)
  ) u_arb (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .slot_free   (slot_free_s),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  // Accept handshake: only the granted requester sees ready.
  always_comb begin
    req_ready = 2'b00;
    if (grant_valid_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
  end

  // ALU operand mux: granted requester passes straight through, else all zero.
  always_comb begin
    alu_aluop = ALU_ADD;
    alu_porta = {WORD_W{1'b0}};
    alu_portb = {WORD_W{1'b0}};
    if (grant_valid_s) begin
      alu_aluop = req_aluop[grant_id_s];
      alu_porta = req_porta[grant_id_s];
      alu_portb = req_portb[grant_id_s];
    end else begin
      alu_aluop = ALU_ADD;
      alu_porta = {WORD_W{1'b0}};
      alu_portb = {WORD_W{1'b0}};
    end
  end

  // Output slot next state: load on accept (also covers consume+accept),
  // empty on consume alone, otherwise hold the result stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    result_d    = result_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (grant_valid_s) begin
      out_valid_d = 1'b1;
      out_id_d    = grant_id_s;
      result_d    = alu_portout;
      neg_d       = alu_negative;
      ovf_d       = alu_overflow;
      zero_d      = alu_zero;
    end else if (out_valid_q && resp_ready[out_id_q]) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output slot registers; reset drops any pending result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      result_q    <= {WORD_W{1'b0}};
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // Response valid is the slot owner, one-hot.
  always_comb begin
    resp_valid = 2'b00;
    if (out_valid_q) begin
      resp_valid[out_id_q] = 1'b1;
    end else begin
      resp_valid = 2'b00;
    end
  end

  assign resp_portout  = result_q;
  assign resp_negative = neg_q;
  assign resp_overflow = ovf_q;
  assign resp_zero     = zero_q;

endmodule
